// File: rtl/mem_arb2_rtl_if.sv
// Bundle of the requester, memory and select signals around the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric / testbench.
interface mem_arb2_rtl_if #(
  parameter int unsigned p_addr_nbits = 32,
  parameter int unsigned p_data_nbits = 32
);
  logic                    req0_val;
  logic                    req0_rdy;
  logic                    req0_type;
  logic [p_addr_nbits-1:0] req0_addr;
  logic [p_data_nbits-1:0] req0_wdata;

  logic                    req1_val;
  logic                    req1_rdy;
  logic                    req1_type;
  logic [p_addr_nbits-1:0] req1_addr;
  logic [p_data_nbits-1:0] req1_wdata;

  logic                    resp0_val;
  logic [p_data_nbits-1:0] resp0_data;
  logic                    resp1_val;
  logic [p_data_nbits-1:0] resp1_data;

  logic                    mem_req_val;
  logic                    mem_req_rdy;
  logic                    mem_req_type;
  logic [p_addr_nbits-1:0] mem_req_addr;
  logic [p_data_nbits-1:0] mem_req_wdata;
  logic                    mem_resp_val;
  logic [p_data_nbits-1:0] mem_resp_data;

  logic                    sel;

  modport slave (
    input  req0_val, req0_type, req0_addr, req0_wdata,
    input  req1_val, req1_type, req1_addr, req1_wdata,
    input  mem_req_rdy, mem_resp_val, mem_resp_data,
    output req0_rdy, req1_rdy,
    output resp0_val, resp0_data, resp1_val, resp1_data,
    output mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata,
    output sel
  );

  modport master (
    output req0_val, req0_type, req0_addr, req0_wdata,
    output req1_val, req1_type, req1_addr, req1_wdata,
    output mem_req_rdy, mem_resp_val, mem_resp_data,
    input  req0_rdy, req1_rdy,
    input  resp0_val, resp0_data, resp1_val, resp1_data,
    input  mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata,
    input  sel
  );
endinterface

// File: rtl/mem_arb2_rtl.sv
// Round-robin arbiter/sequencer sharing one memory port between instruction fetch (0)
// and data access (1); one outstanding transaction, response steered back to its owner.
module mem_arb2_rtl #(
  parameter int unsigned p_addr_nbits = 32,
  parameter int unsigned p_data_nbits = 32
) (
  input  logic            clk,
  input  logic            rst,
  mem_arb2_rtl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q,  prio_d;

  logic   winner;
  logic   sel_c;
  logic   mrv_c;
  logic   rdy0_c, rdy1_c;
  logic   resp0_c, resp1_c;
  logic   owner_val;

  logic                    mux_type;
  logic [p_addr_nbits-1:0] mux_addr;
  logic [p_data_nbits-1:0] mux_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    mrv_c   = 1'b0;
    rdy0_c  = 1'b0;
    rdy1_c  = 1'b0;
    resp0_c = 1'b0;
    resp1_c = 1'b0;

    // A lone requester wins outright; a tie or an empty cycle falls back to prio.
    winner = prio_q;
    if (bus.req0_val ^ bus.req1_val)
      winner = bus.req1_val;

    sel_c     = (state_q == IDLE) ? winner : owner_q;
    owner_val = owner_q ? bus.req1_val : bus.req0_val;

    unique case (state_q)
      IDLE: begin
        if (bus.req0_val || bus.req1_val) begin
          mrv_c   = 1'b1;
          rdy0_c  = ~winner & bus.mem_req_rdy;
          rdy1_c  =  winner & bus.mem_req_rdy;
          owner_d = winner;
          if (bus.mem_req_rdy) begin
            prio_d  = ~winner;
            state_d = WAIT;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        mrv_c  = owner_val;
        rdy0_c = ~owner_q & bus.mem_req_rdy;
        rdy1_c =  owner_q & bus.mem_req_rdy;
        if (owner_val && bus.mem_req_rdy) begin
          prio_d  = ~owner_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_val) begin
          resp0_c = ~owner_q;
          resp1_c =  owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // State is already forced to IDLE by the async reset; this also silences the outputs.
    if (rst) begin
      sel_c   = 1'b0;
      mrv_c   = 1'b0;
      rdy0_c  = 1'b0;
      rdy1_c  = 1'b0;
      resp0_c = 1'b0;
      resp1_c = 1'b0;
    end
  end

  always_comb begin
    mux_type  = sel_c ? bus.req1_type  : bus.req0_type;
    mux_addr  = sel_c ? bus.req1_addr  : bus.req0_addr;
    mux_wdata = sel_c ? bus.req1_wdata : bus.req0_wdata;
  end

  assign bus.sel           = sel_c;
  assign bus.mem_req_val   = mrv_c;
  assign bus.mem_req_type  = mux_type;
  assign bus.mem_req_addr  = mux_addr;
  assign bus.mem_req_wdata = mux_wdata;
  assign bus.req0_rdy      = rdy0_c;
  assign bus.req1_rdy      = rdy1_c;
  assign bus.resp0_val     = resp0_c;
  assign bus.resp1_val     = resp1_c;
  assign bus.resp0_data    = bus.mem_resp_data;
  assign bus.resp1_data    = bus.mem_resp_data;

endmodule

// File: doc/mem_arb2_rtl.md
# mem_arb2_rtl

Two-requester memory-port arbiter and sequencer for the TinyRV1 processor. It shares a single memory request/response port between requester 0 (instruction fetch) and requester 1 (data access). It arbitrates round-robin over val/rdy requests and drives the select of the shared 2:1 request mux. It tracks the single outstanding transaction and steers the response back to its owner. It sits between the processor front end and the memory interface.

## Interface
- p_addr_nbits, 32, request address width
- p_data_nbits, 32, write/read data width

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_val / req1_val  in  1  requester n has a valid request
- req0_rdy / req1_rdy  out  1  arbiter accepts requester n's request
- req0_type / req1_type  in  1  0 = read, 1 = write
- req0_addr / req1_addr  in  p_addr_nbits  request address
- req0_wdata / req1_wdata  in  p_data_nbits  write data
- resp0_val / resp1_val  out  1  response for requester n
- resp0_data / resp1_data  out  p_data_nbits  response data, both equal to mem_resp_data
- mem_req_val  out  1  request to memory
- mem_req_rdy  in  1  memory accepts request
- mem_req_type, mem_req_addr, mem_req_wdata  out  1 / p_addr_nbits / p_data_nbits  muxed request fields
- mem_resp_val  in  1  memory response valid
- mem_resp_data  in  p_data_nbits  memory response data
- sel  out  1  current mux select (0 = requester 0), also drives request mux

## Operation
- Registers:
  - state: IDLE / HOLD / WAIT
  - owner: 1 bit
  - prio: 1 bit, the preferred requester
- Reset values: state=IDLE, owner=0, prio=0.
- Outputs in reset: mem_req_val=0, req*_rdy=0, resp*_val=0, sel=0.
- Winner selection (IDLE only):
  - If exactly one req_val is high, that requester wins.
  - If both are high, requester prio wins.
  - If neither is high, no winner and sel=prio.
- sel = winner in IDLE, owner in HOLD/WAIT.
- mem_req_type/addr/wdata = fields of requester sel, purely combinational mux.
- IDLE:
  - mem_req_val = req_val of the winner.
  - rdy of the winner = mem_req_rdy; rdy of the loser = 0.
  - Fire (val && mem_req_rdy): owner<=winner, prio<=~winner, go to WAIT.
  - Winner valid but mem_req_rdy=0: owner<=winner, go to HOLD. This locks the grant so the offered request cannot switch.
- HOLD:
  - mem_req_val = req_val of owner. The requester must hold val and fields stable once offered.
  - rdy of owner = mem_req_rdy; other requester's rdy = 0.
  - On fire: prio<=~owner, go to WAIT.
- WAIT:
  - mem_req_val=0, both req_rdy=0.
  - On mem_resp_val: resp_val of owner = 1 for that cycle, go to IDLE.
  - The other requester's resp_val stays 0.
- One outstanding transaction maximum. No new request is accepted in the same cycle as a response.
- prio changes only on a fire. A lone requester winning still flips prio away from itself.
- mem_resp_val in IDLE or HOLD is a protocol error. It is ignored: no resp_val is asserted and there is no state change.
- Async reset mid-HOLD or mid-WAIT returns to IDLE immediately. A late response arriving after reset is ignored.

## Timing
- Request path is combinational: zero-cycle req_val to mem_req_val, and mem_req_rdy to req_rdy.
- Response path is combinational: resp_val is asserted in the same cycle as mem_resp_val.
- Minimum transaction occupancy is 2 cycles: fire in cycle N, earliest response in cycle N+1, next fire in cycle N+2.
- Back-to-back responses are impossible by construction.
- No combinational path from mem_resp_val to mem_req_val.

## Test plan
- Reset behaviour: assert rst with both req_val=1 -> all val/rdy outputs 0, sel=0. After deassert, in the first cycle with mem_req_rdy=1, requester 0 fires.
- Round-robin alternation: both requesters continuously valid, mem_req_rdy=1, memory responds 1 cycle after each fire -> fires alternate 0,1,0,1. resp0_val and resp1_val alternate, each matching the owner with data 0xA5A5_0000+n.
- Stall lock: in IDLE, only req1 valid with mem_req_rdy=0 for 3 cycles, and req0 rises in cycle 2 -> state HOLD, sel stays 1, req0_rdy=0. Then mem_req_rdy=1 -> req1 fires with addr 0x0000_2000 and prio becomes 0.
- Single requester repeat: only req0 valid for 4 transactions -> all granted to 0, sel=0, resp1_val never asserted.
- Response routing/spurious: response in WAIT with owner=1 and mem_resp_data=0x1234_5678 -> resp1_val=1, resp0_val=0. A spurious mem_resp_val in IDLE -> both resp_val=0, state unchanged.
- Reset mid-WAIT: assert rst one cycle after fire, then a late mem_resp_val -> no resp_val, state IDLE, prio=0.
